// File: rtl/count_event_pkg.sv
// Shared definitions for the count event FIFO: record kind codes and
// the helper that sizes a {kind, count, timestamp} record.
package count_event_pkg;

  localparam int KIND_W = 2;

  // Kind 00 is never written into the FIFO; it only marks "no event".
  typedef enum logic [KIND_W-1:0] {
    KIND_NONE = 2'b00,
    KIND_HIGH = 2'b01,
    KIND_LOW  = 2'b10,
    KIND_FALL = 2'b11
  } kind_e;

  // Total record width for a given count width and timestamp width.
  function automatic int rec_width(input int count_w, input int ts_w);
    return KIND_W + count_w + ts_w;
  endfunction

endpackage

// File: rtl/sync_event_fifo.sv
// Single-clock event FIFO with registered pop output and sticky overflow.
// A push while full is still accepted when a pop happens in the same cycle.
// The read-before-write ordering of the array lets a full FIFO pop and push
// the same slot in one cycle.
module sync_event_fifo #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW:0]       occ_reg, occ_next;
  logic              overflow_reg, overflow_next;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              do_pop, do_push, drop;

  assign empty    = (occ_reg == '0);
  assign full     = (occ_reg == FULL_OCC);
  assign do_pop   = rd_en && !empty;
  assign do_push  = wr_en && (!full || do_pop);
  assign drop     = wr_en && full && !do_pop;

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign overflow = overflow_reg;

  // Next pointers, occupancy and sticky overflow (a drop beats a clear).
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    occ_next      = occ_reg;
    overflow_next = overflow_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({do_push, do_pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
    if (drop)         overflow_next = 1'b1;
    else if (ovf_clr) overflow_next = 1'b0;
  end

  // Control state and registered read port, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      occ_reg      <= occ_next;
      overflow_reg <= overflow_next;
      rd_valid_reg <= do_pop;
      if (do_pop) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/count_event_fifo.sv
// Edge-detects the upstream counter's high/low flags and logs each event as
// a {kind, count, timestamp} record into sync_event_fifo.
// Optional macro COUNT_EVENT_FIFO_FALL_EN: falling edges of high or low are
// also logged as kind 11 records (lowest priority).
module count_event_fifo
  import count_event_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 count,
  input  logic                             high,
  input  logic                             low,
  input  logic                             rd_en,
  input  logic                             ovf_clr,
  output logic                             rd_valid,
  output logic [KIND_W+WIDTH+TS_WIDTH-1:0] rd_data,
  output logic                             empty,
  output logic                             full,
  output logic                             overflow
);

  localparam int REC_W = rec_width(WIDTH, TS_WIDTH);
  localparam int NFLAG = 2;  // bit 0 = high, bit 1 = low

  logic [TS_WIDTH-1:0] ts_reg, ts_next;
  logic                armed_reg;
  logic [NFLAG-1:0]    flag_now, flag_prev_reg, rise;
`ifdef COUNT_EVENT_FIFO_FALL_EN
  logic [NFLAG-1:0]    fall;
`endif
  kind_e               wr_kind;
  logic                wr_req;
  logic [REC_W-1:0]    wr_rec;

  assign flag_now = {low, high};
  assign ts_next  = ts_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NFLAG; gi++) begin : g_edge
      assign rise[gi] = flag_now[gi] & ~flag_prev_reg[gi];
`ifdef COUNT_EVENT_FIFO_FALL_EN
      assign fall[gi] = ~flag_now[gi] & flag_prev_reg[gi];
`endif
    end
  endgenerate

  // Free-running timestamp, flag history and the one-cycle arming flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_reg        <= '0;
      flag_prev_reg <= '0;
      armed_reg     <= 1'b0;
    end else begin
      ts_reg        <= ts_next;
      flag_prev_reg <= flag_now;
      armed_reg     <= 1'b1;
    end
  end

  // Pick at most one event per cycle: high-rise, then low-rise, then fall.
  always_comb begin
    wr_req  = 1'b0;
    wr_kind = KIND_NONE;
    if (armed_reg) begin
      if (rise[0]) begin
        wr_req  = 1'b1;
        wr_kind = KIND_HIGH;
      end else if (rise[1]) begin
        wr_req  = 1'b1;
        wr_kind = KIND_LOW;
      end
`ifdef COUNT_EVENT_FIFO_FALL_EN
      else if (|fall) begin
        wr_req  = 1'b1;
        wr_kind = KIND_FALL;
      end
`endif
    end
  end

  assign wr_rec = {wr_kind, count, ts_reg};

  sync_event_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_req),
    .wr_data  (wr_rec),
    .rd_en    (rd_en),
    .ovf_clr  (ovf_clr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_count_event_fifo.sv
// Directed bench for count_event_fifo with an expected-record scoreboard.
module tb_count_event_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  count;
  logic        high, low, rd_en, ovf_clr;
  logic        rd_valid;
  logic [13:0] rd_data;
  logic        empty, full, overflow;

  int          checks = 0;
  int          errors = 0;
  logic [13:0] sb[$];
  logic [13:0] last_exp = '0;
  logic [7:0]  model_ts;
  logic        cur_h = 1'b0;

  count_event_fifo #(.WIDTH(4), .DEPTH(8), .TS_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .high     (high),
    .low      (low),
    .rd_en    (rd_en),
    .ovf_clr  (ovf_clr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference timestamp: zero in reset, +1 on every rising edge otherwise.
  always @(posedge clk or negedge rst) begin
    if (!rst) model_ts <= 8'd0;
    else      model_ts <= model_ts + 8'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle in which high and low swap, giving exactly one rise event.
  task automatic toggle_event(input logic [3:0] c, input bit accept,
                              input bit rd, input bit clr);
    cur_h   = ~cur_h;
    high    = cur_h;
    low     = ~cur_h;
    count   = c;
    rd_en   = rd;
    ovf_clr = clr;
    if (accept) sb.push_back({(cur_h ? 2'b01 : 2'b10), c, model_ts});
    step();
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // Compare an already-popped output against the scoreboard head.
  task automatic expect_pop(input string tag);
    logic [13:0] exp;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb observed=empty_queue expected=entry", tag);
    end else begin
      exp      = sb.pop_front();
      last_exp = exp;
      check({tag, "_data"}, 32'(rd_data), 32'(exp));
    end
  endtask

  task automatic pop_check(input string tag);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    expect_pop(tag);
  endtask

  task automatic wait_ts(input logic [7:0] target);
    int guard = 0;
    while (model_ts != target && guard < 400) begin
      step();
      guard++;
    end
    check("ts_wait", 32'(guard < 400), 32'd1);
  endtask

  initial begin
    rst = 1'b1; count = 4'd0; high = 1'b0; low = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0;
    #1 rst = 1'b0;
    #3;
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    step(); step();
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Arming cycle with low already high: nothing may be logged.
    step();
    check("arm_no_event", 32'(empty), 32'd1);
    step();
    check("idle_no_event", 32'(empty), 32'd1);

    // High rises with count at 15.
    cur_h = 1'b1; high = 1'b1; low = 1'b0; count = 4'd15;
    sb.push_back({2'b01, 4'd15, model_ts});
    step();
    check("first_nonempty", 32'(empty), 32'd0);
    pop_check("first_pop");
    check("after_pop_empty", 32'(empty), 32'd1);

    // Pop on empty: ignored, output data held.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("empty_pop_valid", 32'(rd_valid), 32'd0);
    check("empty_pop_hold",  32'(rd_data),  32'(last_exp));

    // Fill to DEPTH, then drop one.
    for (int i = 0; i < 8; i++) begin
      toggle_event(4'(i), 1'b1, 1'b0, 1'b0);
      if (i == 6) check("full_at_7", 32'(full), 32'd0);
    end
    check("full_at_8",  32'(full),     32'd1);
    check("ovf_at_8",   32'(overflow), 32'd0);
    toggle_event(4'd8, 1'b0, 1'b0, 1'b0);
    check("ovf_drop",   32'(overflow), 32'd1);
    check("full_drop",  32'(full),     32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous pop: event accepted, still full.
    toggle_event(4'd9, 1'b1, 1'b1, 1'b0);
    expect_pop("full_rw");
    check("full_rw_ovf",  32'(overflow), 32'd0);
    check("full_rw_full", 32'(full),     32'd1);

    // Drop and clear in the same cycle: the drop wins.
    toggle_event(4'd10, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clear2", 32'(overflow), 32'd0);

    // Drain in back-to-back pops.
    for (int i = 0; i < 8; i++) pop_check("drain");
    check("drain_empty", 32'(empty), 32'd1);

    // Write and pop together at occupancy 1.
    toggle_event(4'd3, 1'b1, 1'b0, 1'b0);
    toggle_event(4'd4, 1'b1, 1'b1, 1'b0);
    expect_pop("mid_rw");
    check("mid_rw_nonempty", 32'(empty), 32'd0);
    pop_check("mid_rw_tail");
    check("mid_rw_empty", 32'(empty), 32'd1);

    // Timestamp wrap: order preserved, second record carries ts 3.
    wait_ts(8'd252);
    toggle_event(4'd12, 1'b1, 1'b0, 1'b0);
    wait_ts(8'd3);
    toggle_event(4'd13, 1'b1, 1'b0, 1'b0);
    pop_check("wrap_first");
    pop_check("wrap_second");
    check("wrap_ts_small", 32'(rd_data[7:0]), 32'd3);

    // Falling edge of high.
    if (!cur_h) begin
      toggle_event(4'd5, 1'b1, 1'b0, 1'b0);
      pop_check("pre_fall");
    end
    high = 1'b0; low = 1'b0; count = 4'd9; cur_h = 1'b0;
`ifdef COUNT_EVENT_FIFO_FALL_EN
    sb.push_back({2'b11, 4'd9, model_ts});
`endif
    step();
    check("fall_empty", 32'(empty), 32'(sb.size() == 0));
    if (sb.size() > 0) begin
      pop_check("fall_pop");
    end else begin
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("fall_no_valid", 32'(rd_valid), 32'd0);
      check("fall_hold",     32'(rd_data),  32'(last_exp));
    end

    // Reset mid-stream discards stored entries at once.
    high = 1'b1; cur_h = 1'b1; count = 4'd7;
    step();
    check("pre_rst_nonempty", 32'(empty), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_empty",    32'(empty),    32'd1);
    check("mid_rst_full",     32'(full),     32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    sb.delete();
    step();
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
